// File: rtl/cdc_stream_pkg.sv
// Shared types and helpers for the clk_1 -> clk_2 stream bridge.
package cdc_stream_pkg;

  localparam int unsigned MODE_SUM  = 0;
  localparam int unsigned MODE_PASS = 1;
  localparam int unsigned MODE_POP  = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK_LO
  } src_state_e;

  typedef enum logic [1:0] {
    D_IDLE,
    D_ACK,
    D_WAIT_REQ_LO
  } dst_state_e;

  // Significant result bits produced by each transform before zero-extension.
  function automatic int unsigned out_width(input int unsigned mode, input int unsigned data_w);
    case (mode)
      MODE_SUM: return data_w / 2 + 1;
      MODE_POP: return $clog2(data_w + 1);
      default:  return data_w;
    endcase
  endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchroniser with asynchronous active-low clear.
module cdc_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else        chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_stream_bridge.sv
// Buffered clk_1 -> clk_2 word bridge: source FIFO, 4-phase req/ack crossing,
// destination transform with valid/ready output.
module cdc_stream_bridge
  import cdc_stream_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MODE        = MODE_SUM
) (
  input  logic              clk_1,
  input  logic              clk_2,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              overflow,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned PW     = AW + 1;
  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned RES_W  = out_width(MODE, DATA_W);

  logic rst1_n;
  logic rst2_n;
  logic req;
  logic ack;
  logic req_sync;
  logic ack_sync;

  // Per-domain reset: asynchronous assert, synchronised release.
  cdc_sync_bit #(.SYNC_STAGES(2)) u_rst1_sync (
    .clk   (clk_1),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst1_n)
  );

  cdc_sync_bit #(.SYNC_STAGES(2)) u_rst2_sync (
    .clk   (clk_2),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst2_n)
  );

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk_2),
    .rst_n (rst2_n),
    .d     (req),
    .q     (req_sync)
  );

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk_1),
    .rst_n (rst1_n),
    .d     (ack),
    .q     (ack_sync)
  );

  // ---------------------------------------------------------------- source FIFO
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr_nxt_c;
  logic [PW-1:0]     rd_ptr_nxt_c;
  logic              wr_en_c;
  logic              pop_c;
  logic              empty_c;
  logic              full_nxt_c;

  // in_ready mirrors !full, so a write while full is impossible even with a pop.
  assign wr_en_c      = in_valid && in_ready;
  assign empty_c      = (wr_ptr == rd_ptr);
  assign wr_ptr_nxt_c = wr_ptr + PW'(wr_en_c);
  assign rd_ptr_nxt_c = rd_ptr + PW'(pop_c);
  assign full_nxt_c   = (wr_ptr_nxt_c[AW] != rd_ptr_nxt_c[AW]) &&
                        (wr_ptr_nxt_c[AW-1:0] == rd_ptr_nxt_c[AW-1:0]);

  always_ff @(posedge clk_1) begin
    if (wr_en_c) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk_1 or negedge rst1_n) begin
    if (!rst1_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt_c;
      rd_ptr   <= rd_ptr_nxt_c;
      in_ready <= !full_nxt_c;
      if (in_valid && !in_ready) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- source FSM
  src_state_e        src_state;
  src_state_e        src_nxt_c;
  logic              req_nxt_c;
  logic [DATA_W-1:0] hold_reg;

  always_ff @(posedge clk_1 or negedge rst1_n) begin
    if (!rst1_n) begin
      src_state <= S_IDLE;
      req       <= 1'b0;
      hold_reg  <= '0;
    end else begin
      src_state <= src_nxt_c;
      req       <= req_nxt_c;
      if (pop_c) hold_reg <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_comb begin
    src_nxt_c = src_state;
    req_nxt_c = req;
    pop_c     = 1'b0;
    unique case (src_state)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c     = 1'b1;
          req_nxt_c = 1'b1;
          src_nxt_c = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_sync) begin
          req_nxt_c = 1'b0;
          src_nxt_c = S_WAIT_ACK_LO;
        end
      end
      S_WAIT_ACK_LO: begin
        if (!ack_sync) src_nxt_c = S_IDLE;
      end
      default: src_nxt_c = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- destination
  function automatic logic [DATA_W-1:0] transform(input logic [DATA_W-1:0] d);
    logic [RES_W-1:0] res;
    res = '0;
    if (MODE == MODE_SUM) begin
      res = RES_W'(d[DATA_W-1:HALF_W]) + RES_W'(d[HALF_W-1:0]);
    end else if (MODE == MODE_POP) begin
      for (int i = 0; i < int'(DATA_W); i++) res = res + RES_W'(d[i]);
    end else begin
      res = RES_W'(d);
    end
    return DATA_W'(res);
  endfunction

  dst_state_e dst_state;
  dst_state_e dst_nxt_c;
  logic       ack_nxt_c;
  logic       cap_c;
  logic       slot_free_c;

  assign slot_free_c = !out_valid || out_ready;

  // hold_reg has been stable since req rose, so it is sampled directly here.
  always_ff @(posedge clk_2 or negedge rst2_n) begin
    if (!rst2_n) begin
      dst_state <= D_IDLE;
      ack       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      dst_state <= dst_nxt_c;
      ack       <= ack_nxt_c;
      if (cap_c) begin
        out_valid <= 1'b1;
        out_data  <= transform(hold_reg);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    dst_nxt_c = dst_state;
    ack_nxt_c = ack;
    cap_c     = 1'b0;
    unique case (dst_state)
      D_IDLE: begin
        if (req_sync && slot_free_c) begin
          cap_c     = 1'b1;
          ack_nxt_c = 1'b1;
          dst_nxt_c = D_ACK;
        end
      end
      D_ACK: begin
        if (!req_sync) begin
          ack_nxt_c = 1'b0;
          dst_nxt_c = D_WAIT_REQ_LO;
        end
      end
      D_WAIT_REQ_LO: dst_nxt_c = D_IDLE;
      default:       dst_nxt_c = D_IDLE;
    endcase
  end

endmodule

// File: doc/cdc_stream_bridge.md
Name: cdc_stream_bridge

Overview:
Parametrised clock-domain-crossing bridge that carries a stream of words from the clk_1 domain to the clk_2 domain. It buffers input bursts in a source-side FIFO and moves each word across with a 4-phase req/ack handshake. In the destination domain it applies a selectable transform and presents the result with valid/ready backpressure. It is the successor to the single-word, non-buffered, nibble-sum CDC stage and sits between the clk_1 front end and clk_2 consumers.

Parameters:
DATA_W, 8, input word width; must be even and at least 2.
DEPTH, 4, source FIFO depth in entries; must be a power of 2 and at least 2.
SYNC_STAGES, 2, flop count in each req/ack synchroniser chain; must be at least 2.
MODE, 0, transform: 0 = sum of upper and lower halves, 1 = pass-through, 2 = popcount.

Ports:
clk_1  in  1  source-domain clock.
clk_2  in  1  destination-domain clock.
rst_n  in  1  asynchronous active-low reset, shared by both domains.
in_valid  in  1  clk_1 domain: input word valid.
in_data  in  DATA_W  clk_1 domain: input word.
in_ready  out  1  clk_1 domain: FIFO not full.
overflow  out  1  clk_1 domain: sticky flag, set when in_valid && !in_ready.
out_valid  out  1  clk_2 domain: result valid.
out_data  out  DATA_W  clk_2 domain: transformed word, zero-extended.
out_ready  in  1  clk_2 domain: consumer accepts.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk_1 for the source side and clk_2 for the destination side.
- Assertion of rst_n is asynchronous in both domains. Each domain deasserts its reset through its own 2-flop reset synchroniser.
- Reset values: in_ready=0 while in reset, then 1; overflow=0; out_valid=0; out_data=0. FIFO empty; req=0; ack=0.
- Source FIFO (clk_1):
  - Write when in_valid && in_ready.
  - A word offered while full is dropped and sets overflow, which clears only on reset.
  - A simultaneous read and write while full is not a write; in_ready is registered from the full state.
- Source FSM (clk_1), states S_IDLE, S_REQ, S_WAIT_ACK_LO:
  - S_IDLE: if FIFO non-empty, pop the head into hold_reg, set req=1, go to S_REQ.
  - S_REQ: when synced ack=1, set req=0, go to S_WAIT_ACK_LO.
  - S_WAIT_ACK_LO: when synced ack=0, go to S_IDLE.
- hold_reg is stable from req rising until ack is seen low. This is the only multi-bit signal crossing domains, and it is never synchronised bitwise.
- Destination FSM (clk_2), states D_IDLE, D_ACK, D_WAIT_REQ_LO:
  - D_IDLE: when synced req=1 and the output slot is free, capture hold_reg through the transform into out_data, set out_valid=1 and ack=1, go to D_ACK.
  - The output slot is free when !out_valid || out_ready.
  - D_ACK: when synced req=0, set ack=0, go to D_WAIT_REQ_LO (one cycle), then D_IDLE.
- Output: out_valid/out_data hold until out_ready=1. out_valid deasserts on the accepting edge unless a new capture occurs on that same edge, in which case it stays 1 with new data.
- Transforms:
  - MODE 0: upper half plus lower half, result width DATA_W/2+1, zero-extended.
  - MODE 1: identity.
  - MODE 2: count of ones.
- Latency, in_valid to out_valid with an empty FIFO and out_ready=1: 1 clk_1 cycle, plus up to SYNC_STAGES+1 clk_2 cycles, plus 1 clk_2 cycle.
- Throughput: one word per full 4-phase round trip.
- Each accepted word produces exactly one output, in order. No duplicates and no loss except overflow drops.
- Backpressure: with out_ready=0 the destination stalls in D_IDLE without acking. The FIFO then fills and in_ready falls.
- Reset mid-transfer: the in-flight word and all FIFO contents are discarded, and no partial output appears.

Decomposition:
- Package cdc_stream_pkg: MODE_SUM, MODE_PASS and MODE_POP constants; src_state_e and dst_state_e enums; a function out_width(MODE, DATA_W).
- Sub-module cdc_sync_bit: SYNC_STAGES-deep single-bit synchroniser with async reset. Instantiated twice (req into clk_2, ack into clk_1) and reused for the two reset synchronisers.
- FIFO is inline, using pointers with a wrap bit.

Test Plan:
- MODE0, DATA_W=8, clk_1=10ns, clk_2=37ns; single word 0xF7 -> one out_valid pulse with out_data=0x16 (15+7); no further outputs.
- MODE0, burst of 4 back-to-back words 0x11,0x22,0xFF,0x80 with DEPTH=4 -> in_ready stays 1; outputs 0x02,0x04,0x1E,0x08 in order; overflow=0.
- Burst of 7 words while out_ready=0 -> 4 stored plus 1 in hold_reg; in_ready low on the 6th word; overflow=1. After out_ready=1, exactly 5 outputs in order.
- out_ready toggles every other clk_2 cycle; clk_2 faster (3ns) than clk_1 -> out_data stable while out_valid && !out_ready; no lost or duplicated words over 200 random words (scoreboard).
- MODE1 and MODE2, DATA_W=16, word 0xA5F0 -> out_data 0xA5F0 and 0x0008 respectively.
- rst_n pulsed low while req=1 and ack=0 -> all outputs return to reset values asynchronously; after release, a new word 0x33 gives a single output 0x06 (MODE0).
